arm_regfile: RTL and testbench
==============================

Name: arm_regfile

Overview:
- ARMv8 general-purpose register file for the decode stage of the single-issue core.
- 32 architectural registers X0..X31, each `WORD bits wide.
- Two combinational read ports (Rn, Rm) and one synchronous write port (Rd).
- Register 31 is XZR: it always reads zero and ignores writes.

Parameters:
- WORD, 64, data width in bits; sourced from the shared `WORD define.
- NREGS, 32, number of architectural registers; fixed at 32 with 5-bit addresses.

Ports:
- clk  input  1  single clock for the block; writes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- regWrite  input  1  write enable for the write port.
- read_reg1  input  5  Rn read address.
- read_reg2  input  5  Rm read address.
- write_reg  input  5  Rd write address.
- write_data  input  WORD  data to write.
- read_data1  output  WORD  contents of read_reg1.
- read_data2  output  WORD  contents of read_reg2.

Behaviour:
- Storage: 31 physical WORD-bit registers for X0..X30; X31 has no storage.
- Reset:
  - On reset assertion, X0..X30 clear to 0 immediately, without waiting for a clock edge.
  - Both read outputs show 0 while reset is high.
  - Writes are blocked while reset is high.
  - Deassertion takes effect at the next clk rising edge.
- Write:
  - At posedge clk with regWrite=1, reset=0 and write_reg != 31, X[write_reg] <= write_data.
  - Writes with write_reg=31 are discarded.
  - regWrite=0 leaves all registers unchanged.
- Read:
  - Purely combinational, zero latency.
  - read_dataN = 0 if read_regN == 31; otherwise X[read_regN].
- Write-first bypass:
  - If regWrite=1, write_reg == read_regN and write_reg != 31 in the same cycle, read_dataN = write_data combinationally.
  - The new value therefore appears before the clock edge commits it.
  - Both read ports bypass independently.
- Address width: addresses are exactly 5 bits. An upstream value of 32 truncates to 0 and reads X0; this is the required behaviour.
- Same address on both read ports returns identical data.
- No X/undefined outputs after reset for any address.

Decomposition:
- Shared definitions header (definitions.vh):
  - `WORD (64).
  - `CYCLE (simulation clock period).
  - Constant XZR_IDX = 31.
- No sub-module is needed in synthesizable RTL.
- The oscillator module is a simulation-only free-running clock source:
  - Single output clk.
  - Period `CYCLE, 50% duty, starts low.
  - Lives with the benches, not in this block.

Test Plan:
- Reset, then read_reg1=10 and read_reg2=15 -> read_data1=0 and read_data2=0; all 31 registers read 0.
- regWrite=1, write_reg=9, write_data=256; one edge later set regWrite=0, read_reg1=9 -> read_data1=256, and X10 still reads 0.
- regWrite=1, write_reg=31, write_data=64'hDEAD_BEEF -> read_reg1=31 reads 0, both before and after the edge.
- Bypass: regWrite=1, write_reg=5, write_data=64'h1234, read_reg2=5, before the edge -> read_data2=64'h1234 in the same cycle; after the edge it still reads 64'h1234.
- Address wrap: write 7 to X0, then drive read_reg1=32 (truncates to 0) and read_reg2=2 -> read_data1=7, read_data2=0.
- Reset mid-operation: X9=256, assert reset between edges -> read_data1 (read_reg1=9) goes to 0 immediately; a write attempted during reset has no effect after reset release.

Source files
------------

// File: rtl/arm_regfile_pkg.sv
// Shared types and constants for the ARMv8 general-purpose register file.
// XZR_IDX names the zero register, which has no backing storage.
package arm_regfile_pkg;

  localparam int WORD    = 64;
  localparam int NREGS   = 32;
  localparam int AW      = 5;
  localparam int XZR_IDX = 31;

  typedef logic [WORD-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;

  function automatic logic is_xzr(input reg_addr_t addr);
    return addr == reg_addr_t'(XZR_IDX);
  endfunction

endpackage

// File: rtl/arm_regfile_if.sv
// Register-file access bundle: one write port (Rd) and two read ports (Rn, Rm).
// The decode stage drives the master side; the register file is the slave.
interface arm_regfile_if;
  import arm_regfile_pkg::*;

  logic      regWrite;
  reg_addr_t read_reg1;
  reg_addr_t read_reg2;
  reg_addr_t write_reg;
  word_t     write_data;
  word_t     read_data1;
  word_t     read_data2;

  modport master (
    output regWrite, read_reg1, read_reg2, write_reg, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  regWrite, read_reg1, read_reg2, write_reg, write_data,
    output read_data1, read_data2
  );

endinterface

// File: rtl/arm_regfile.sv
// ARMv8 register file: X0..X30 in flops, X31 reads as zero, combinational
// reads with write-first bypass, synchronous write, asynchronous clear.
module arm_regfile
  import arm_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  arm_regfile_if.slave bus
);

  word_t     r_x [0:NREGS-2];
  logic      w_wr_en;
  reg_addr_t w_raddr [2];

  // Writes are suppressed during reset so the bypass path cannot leak them.
  assign w_wr_en    = bus.regWrite && !reset && !is_xzr(bus.write_reg);
  assign w_raddr[0] = bus.read_reg1;
  assign w_raddr[1] = bus.read_reg2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS-1; i++) begin
        r_x[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_x[bus.write_reg] <= bus.write_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      word_t w_rdata;

      always_comb begin
        w_rdata = '0;
        if (!reset && !is_xzr(w_raddr[gi])) begin
          if (w_wr_en && (bus.write_reg == w_raddr[gi])) begin
            w_rdata = bus.write_data;
          end else begin
            w_rdata = r_x[w_raddr[gi]];
          end
        end
      end
    end
  endgenerate

  assign bus.read_data1 = g_rd[0].w_rdata;
  assign bus.read_data2 = g_rd[1].w_rdata;

endmodule

// File: tb/tb_arm_regfile.sv
// Self-checking bench for arm_regfile: vector table plus reset corner sequences,
// with expected read data queued at drive time and popped at sample time.
module tb_arm_regfile;
  import arm_regfile_pkg::*;

  logic clk;
  logic reset;

  arm_regfile_if bus ();

  arm_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic [5:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
    string       name;
  } vec_t;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add_vec(input logic we, input logic [4:0] wreg, input logic [63:0] wdata,
                         input logic [5:0] r1, input logic [4:0] r2,
                         input logic [63:0] e1, input logic [63:0] e2, input string name);
    vec_t v;
    v.we = we; v.wreg = wreg; v.wdata = wdata; v.r1 = r1; v.r2 = r2;
    v.e1 = e1; v.e2 = e2; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [63:0] wdata,
                       input logic [5:0] r1, input logic [4:0] r2);
    bus.regWrite   = we;
    bus.write_reg  = wreg;
    bus.write_data = wdata;
    bus.read_reg1  = r1[4:0];
    bus.read_reg2  = r2;
  endtask

  task automatic push_exp(input logic [63:0] e1, input logic [63:0] e2, input string name);
    exp_t e;
    e.e1 = e1; e.e2 = e2; e.name = name;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (bus.read_data1 !== e.e1) begin
      n_err++;
      $display("FAIL %s rd1 got %h want %h", e.name, bus.read_data1, e.e1);
    end
    n_cmp++;
    if (bus.read_data2 !== e.e2) begin
      n_err++;
      $display("FAIL %s rd2 got %h want %h", e.name, bus.read_data2, e.e2);
    end
    $display("t=%0t %s we=%0b wr=%0d rr1=%0d rr2=%0d rd1=%h rd2=%h", $time, e.name,
             bus.regWrite, bus.write_reg, bus.read_reg1, bus.read_reg2,
             bus.read_data1, bus.read_data2);
  endtask

  initial begin
    // Each vector is checked before the following rising edge commits it.
    add_vec(0,  0, 64'h0,    6'd10, 5'd15, 64'h0,    64'h0,    "rst_read");
    add_vec(1,  9, 64'd256,  6'd9,  5'd10, 64'd256,  64'h0,    "wr9_bypass");
    add_vec(0, 10, 64'd99,   6'd9,  5'd10, 64'd256,  64'h0,    "rd9_we0");
    add_vec(1, 31, 64'hDEAD_BEEF, 6'd31, 5'd9, 64'h0, 64'd256, "wr31_pre");
    add_vec(0,  0, 64'h0,    6'd31, 5'd10, 64'h0,    64'h0,    "wr31_post");
    add_vec(1,  5, 64'h1234, 6'd9,  5'd5,  64'd256,  64'h1234, "bypass_rm");
    add_vec(0,  0, 64'h0,    6'd5,  5'd5,  64'h1234, 64'h1234, "same_addr");
    add_vec(1,  0, 64'd7,    6'd0,  5'd2,  64'd7,    64'h0,    "wr0_bypass");
    add_vec(0,  0, 64'h0,    6'd32, 5'd2,  64'd7,    64'h0,    "addr_wrap");
    add_vec(1, 30, {64{1'b1}}, 6'd30, 5'd29, {64{1'b1}}, 64'h0, "x30_bypass");
    add_vec(0,  0, 64'h0,    6'd30, 5'd0,  {64{1'b1}}, 64'd7,  "x30_read");
    add_vec(1,  9, 64'hA5,   6'd9,  5'd9,  64'hA5,   64'hA5,   "dual_bypass");
    add_vec(0,  0, 64'h0,    6'd9,  5'd5,  64'hA5,   64'h1234, "x9_commit");

    reset = 1'b1;
    drive(0, 0, 64'h0, 6'd10, 5'd15);
    #1;
    push_exp(64'h0, 64'h0, "rst_hold");
    sample();
    drive(1, 3, 64'h77, 6'd3, 5'd3);
    push_exp(64'h0, 64'h0, "rst_wr_bypass_blk");
    sample();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 64'h0, 6'd3, 5'd0);
    push_exp(64'h0, 64'h0, "rst_release_x3");
    sample();

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      push_exp(vecs[i].e1, vecs[i].e2, vecs[i].name);
      sample();
    end

    // Reset asserted between edges must clear storage immediately.
    @(negedge clk);
    drive(1, 9, 64'd256, 6'd9, 5'd3);
    push_exp(64'd256, 64'h0, "mid_wr9");
    sample();
    @(negedge clk);
    drive(0, 0, 64'h0, 6'd9, 5'd30);
    push_exp(64'd256, {64{1'b1}}, "mid_pre_rst");
    sample();
    #1;
    reset = 1'b1;
    push_exp(64'h0, 64'h0, "mid_rst_async");
    sample();
    @(negedge clk);
    drive(1, 9, 64'h55, 6'd9, 5'd9);
    push_exp(64'h0, 64'h0, "mid_rst_wr_try");
    sample();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 64'h0, 6'd9, 5'd30);
    push_exp(64'h0, 64'h0, "post_rst_x9");
    sample();

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(0, 0, 64'h0, 6'(i), 5'(31 - i));
      push_exp(64'h0, 64'h0, $sformatf("sweep_zero_%0d", i));
      sample();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
